// File: rtl/ao486_rst_seq_pkg.sv
// rtl/ao486_rst_seq_pkg.sv - shared types and constants for the ao486 reset sequencer
package ao486_rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD       = 2'd0,
    ST_WAIT_READY = 2'd1,
    ST_PERIPH     = 2'd2,
    ST_RUN        = 2'd3
  } seq_state_t;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_STRETCH = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_RSVD    = 2'd3;

  localparam int unsigned STRETCH_RST_DEFAULT = 16;
  localparam int unsigned CNT_W_DEFAULT       = 16;
  localparam logic        HOLD_RST            = 1'b1;

endpackage

// File: rtl/ao486_rst_sequencer.sv
// rtl/ao486_rst_sequencer.sv - boot/restart reset sequencer for the ao486 core and peripherals
// Software releases HOLD; the block waits for memory, stretches peripheral-only reset, then runs.
module ao486_rst_sequencer
  import ao486_rst_seq_pkg::*;
#(
  parameter int unsigned STRETCH_RST = STRETCH_RST_DEFAULT,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        mem_ready,
  output logic        periph_rst,
  output logic        ao486_rst,
  output logic        running
);

  seq_state_t       state;
  seq_state_t       state_next;
  logic             hold_bit;
  logic [15:0]      stretch;
  logic [15:0]      counter;
  logic [CNT_W-1:0] restart_cnt;

  logic             ctrl_wr;
  logic             stretch_wr;
  logic             force_hold;
  logic [15:0]      load_val;
  logic [15:0]      cnt_view;
  logic [31:0]      read_mux;
  logic             unused_writedata;

  assign ctrl_wr          = write && (address == ADDR_CTRL);
  assign stretch_wr       = write && (address == ADDR_STRETCH);
  assign force_hold       = ctrl_wr && (writedata[0] || writedata[1]);
  // A zero stretch still yields one PERIPH cycle so the peripherals see reset release first.
  assign load_val         = (stretch == 16'd0) ? 16'd1 : stretch;
  assign cnt_view         = 16'(restart_cnt);
  assign unused_writedata = ^writedata[31:16];

  always_comb begin
    state_next = state;
    if (force_hold) begin
      state_next = ST_HOLD;
    end else if (!mem_ready && (state == ST_PERIPH || state == ST_RUN)) begin
      state_next = ST_HOLD;
    end else begin
      case (state)
        ST_HOLD:       if (!hold_bit) state_next = ST_WAIT_READY;
        ST_WAIT_READY: if (mem_ready) state_next = ST_PERIPH;
        ST_PERIPH:     if (counter == 16'd1) state_next = ST_RUN;
        ST_RUN:        state_next = ST_RUN;
        default:       state_next = ST_HOLD;
      endcase
    end
  end

  always_comb begin
    read_mux = 32'd0;
    case (address)
      ADDR_CTRL:    read_mux = {31'd0, hold_bit};
      ADDR_STRETCH: read_mux = {16'd0, stretch};
      ADDR_STATUS:  read_mux = {cnt_view, 13'd0, mem_ready, state};
      ADDR_RSVD:    read_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state       <= ST_HOLD;
      hold_bit    <= HOLD_RST;
      stretch     <= 16'(STRETCH_RST);
      counter     <= 16'd0;
      restart_cnt <= '0;
      readdata    <= 32'd0;
      periph_rst  <= 1'b1;
      ao486_rst   <= 1'b1;
      running     <= 1'b0;
    end else begin
      state <= state_next;
      if (ctrl_wr)    hold_bit <= writedata[0];
      if (stretch_wr) stretch  <= writedata[15:0];

      // The count is latched on PERIPH entry, so STRETCH writes only affect later passes.
      if (state == ST_WAIT_READY && state_next == ST_PERIPH) begin
        counter <= load_val;
      end else if (state == ST_PERIPH) begin
        counter <= counter - 16'd1;
      end

      if (state_next == ST_RUN && state != ST_RUN && restart_cnt != '1) begin
        restart_cnt <= restart_cnt + CNT_W'(1);
      end

      if (read) readdata <= read_mux;

      periph_rst <= (state_next == ST_HOLD) || (state_next == ST_WAIT_READY);
      ao486_rst  <= (state_next != ST_RUN);
      running    <= (state_next == ST_RUN);
    end
  end

endmodule
